// File: rtl/fu_arbiter_if.sv
// fu_arbiter_if: request/response bundle between four requesters and fu_arbiter.
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_a/req_b         : 32-bit operands, requester i on [32i+31:32i]
//   req_op              : 4-bit opcode, requester i on [4i+3:4i]
//   rsp_valid/rsp_ready : single shared response handshake
//   rsp_id/rsp_data/rsp_err : owner index, result, illegal-opcode flag
// master = requester/consumer side, slave = arbiter side.
interface fu_arbiter_if;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [15:0]  req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/fu_arbiter.sv
// fu_arbiter: time-shares one 32-bit functional unit among four requesters.
// Round-robin grant in IDLE, operation in EXEC (MULT_CYCLES cycles for MULT,
// one cycle otherwise), result held in RESP until the consumer accepts it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fu_arbiter_if.slave request/response bundle
//   busy       : high whenever the FSM is not IDLE
// Build option: define FU_ARB_OPCHK_EN to send opcodes 9..15 straight to
// RESP with rsp_err=1; otherwise they run a 1-cycle EXEC yielding 0, err=0.
module fu_arbiter #(
    parameter int MULT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fu_arbiter_if.slave bus,
    output logic        busy
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MULT = 4'd2,
                           OP_SLL = 4'd3, OP_SRL = 4'd4, OP_AND  = 4'd5,
                           OP_OR  = 4'd6, OP_NOT = 4'd7, OP_XOR  = 4'd8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  id_q, id_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        gnt_vld;
    logic [1:0]  gnt_id, scan_idx;
    logic [3:0]  gnt_op;
    logic [3:0]  ready;
    logic [31:0] fu_res;

    // Round-robin search upward from rr_ptr, 2-bit index wraps 3->0.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = rr_ptr_q;
        scan_idx = '0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!gnt_vld && bus.req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan_idx;
            end
        end
    end

    assign gnt_op = bus.req_op[4*gnt_id +: 4];

    // Shared datapath. Shifts by >= 32 fall out as 0; illegal opcodes give 0.
    always_comb begin
        fu_res = '0;
        case (op_q)
            OP_ADD:  fu_res = a_q + b_q;
            OP_SUB:  fu_res = a_q - b_q;
            OP_MULT: fu_res = a_q * b_q;
            OP_SLL:  fu_res = a_q << b_q;
            OP_SRL:  fu_res = a_q >> b_q;
            OP_AND:  fu_res = a_q & b_q;
            OP_OR:   fu_res = a_q | b_q;
            OP_NOT:  fu_res = ~a_q;
            OP_XOR:  fu_res = a_q ^ b_q;
            default: fu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        data_d   = data_q;
        err_d    = err_q;
        ready    = '0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ready    = 4'b0001 << gnt_id;
                    a_d      = bus.req_a[32*gnt_id +: 32];
                    b_d      = bus.req_b[32*gnt_id +: 32];
                    op_d     = gnt_op;
                    id_d     = gnt_id;
                    rr_ptr_d = gnt_id + 2'd1;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = EXEC;
`ifdef FU_ARB_OPCHK_EN
                    if (gnt_op > OP_XOR) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            EXEC: begin
                if (op_q != OP_MULT || cnt_q == 2'(MULT_CYCLES - 1)) begin
                    data_d  = fu_res;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Grant is combinational from state_q, so mask it while reset is held.
    assign bus.req_ready = rst_n ? ready : 4'b0000;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
`ifdef FU_ARB_OPCHK_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_fu_arbiter.sv
module tb_fu_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_chk = 0;
    int   n_pass = 0;

    fu_arbiter_if bus ();

    fu_arbiter #(.MULT_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

`ifdef FU_ARB_OPCHK_EN
    localparam int          ILL_LAT = 1;
    localparam logic [31:0] ILL_ERR = 32'd1;
`else
    localparam int          ILL_LAT = 2;
    localparam logic [31:0] ILL_ERR = 32'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[4*id +: 4] = op;
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
    endtask

    // Called just after a rising edge with the DUT idle. Issues one request,
    // checks grant, latency and response, optionally stalls the response.
    task automatic xact(input int id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ed,
                        input logic [31:0] ee, input int stall);
        int n;
        set_req(id, op, a, b);
        bus.req_valid = 4'b0001 << id;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("grant", 32'(bus.req_ready), 32'(4'b0001 << id));
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 1;
        @(negedge clk);
        chk("busy_exec", 32'(busy), 32'd1);
        while (!bus.rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_err", 32'(bus.rsp_err), ee);
        if (stall > 0) begin
            bus.req_valid = 4'hF;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
                chk("stall_data", bus.rsp_data, ed);
                chk("stall_id", 32'(bus.rsp_id), 32'(id));
                chk("stall_ready", 32'(bus.req_ready), 32'd0);
            end
            bus.req_valid = '0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int got, cyc;
        logic [1:0]  rr_exp [5];
        logic [31:0] rr_dat [4];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_dat = '{32'h0000_0008, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};

        // Reset state with every requester asking.
        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_data", bus.rsp_data, 32'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        xact(1, 4'd0, 32'hFFFF_FFFF, 32'd2,        2, 32'h0000_0001, 0, 5);
        xact(2, 4'd2, 32'h0001_0000, 32'h0001_0003, 3, 32'h0003_0000, 0, 0);
        xact(2, 4'd12, 32'h1234_5678, 32'd1,       ILL_LAT, 32'd0, ILL_ERR, 0);
        xact(0, 4'd1, 32'd3,         32'd5,        2, 32'hFFFF_FFFE, 0, 0);
        xact(3, 4'd3, 32'd1,         32'd32,       2, 32'h0000_0000, 0, 0);
        xact(1, 4'd3, 32'd3,         32'd31,       2, 32'h8000_0000, 0, 0);
        xact(0, 4'd4, 32'h8000_0000, 32'd31,       2, 32'h0000_0001, 0, 0);
        xact(2, 4'd7, 32'h0F0F_0F0F, 32'h1234_5678, 2, 32'hF0F0_F0F0, 0, 0);
        xact(3, 4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 2, 32'h0F00_0F00, 0, 0);
        xact(0, 4'd6, 32'hF000_0000, 32'h0000_000F, 2, 32'hF000_000F, 0, 0);
        xact(1, 4'd8, 32'hAAAA_5555, 32'hFFFF_0000, 2, 32'h5555_5555, 0, 0);

        // Reset in the middle of a MULT execute.
        set_req(3, 4'd2, 32'd7, 32'd9);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("mrst_grant", 32'(bus.req_ready), 32'h8);
        @(posedge clk); #1;
        set_req(0, 4'd0, 32'd5, 32'd3);
        set_req(1, 4'd1, 32'd5, 32'd7);
        set_req(2, 4'd3, 32'd1, 32'd33);
        set_req(3, 4'd8, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("mrst_busy1", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mrst_ready", 32'(bus.req_ready), 32'd0);
        chk("mrst_data", bus.rsp_data, 32'd0);
        chk("mrst_id", 32'(bus.rsp_id), 32'd0);
        chk("mrst_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;

        // All four requesting, consumer always ready: round-robin from 0.
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid) begin
                chk("rr_id", 32'(bus.rsp_id), 32'(rr_exp[got]));
                chk("rr_data", bus.rsp_data, rr_dat[rr_exp[got]]);
                got++;
            end
        end
        chk("rr_count", 32'(got), 32'd5);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
